bf_weight_sequencer: RTL and testbench

Schedules complex beamforming weights for a bank of `axis_multiplier` channels. It holds a host-written weight table of NUM_CHANNELS × TABLE_DEPTH complex entries and steps through it on packet boundaries of the multiplier input stream. It drives every channel's `bWeight_real`/`bWeight_imag` so that weights only ever change between packets, never mid-packet. It sits between the configuration register file and the multiplier bank.

---
 rtl/bf_weight_sequencer.sv | 128 ++++++++++++
 tb/tb_bf_weight_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bf_weight_sequencer.sv
// bf_weight_sequencer: steps a host-written complex weight table on packet
// boundaries of the monitored multiplier stream, so weights only change between packets.
module bf_weight_sequencer #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int TABLE_DEPTH  = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int CH_WIDTH     = 2,
    parameter int DWELL_WIDTH  = 16
) (
    input  logic                                 clock,
    input  logic                                 resetn,
    input  logic                                 cfg_wr_en,
    input  logic [CH_WIDTH-1:0]                  cfg_wr_ch,
    input  logic [ADDR_WIDTH-1:0]                cfg_wr_idx,
    input  logic [WEIGHT_WIDTH-1:0]              cfg_wr_real,
    input  logic [WEIGHT_WIDTH-1:0]              cfg_wr_imag,
    input  logic [ADDR_WIDTH:0]                  cfg_num_entries,
    input  logic [DWELL_WIDTH-1:0]               cfg_dwell,
    input  logic                                 cfg_loop,
    input  logic                                 cfg_start,
    input  logic                                 cfg_stop,
    input  logic                                 mon_tvalid,
    input  logic                                 mon_tready,
    input  logic                                 mon_tlast,
    output logic [NUM_CHANNELS*WEIGHT_WIDTH-1:0] bWeight_real_bus,
    output logic [NUM_CHANNELS*WEIGHT_WIDTH-1:0] bWeight_imag_bus,
    output logic                                 weight_update,
    output logic [ADDR_WIDTH-1:0]                entry_idx,
    output logic                                 busy,
    output logic                                 done
);
    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
    localparam logic [ADDR_WIDTH:0] DEPTH_N = (ADDR_WIDTH+1)'(TABLE_DEPTH);
    state_t state, state_nxt;
    logic [WEIGHT_WIDTH-1:0] tbl_re [NUM_CHANNELS][TABLE_DEPTH];
    logic [WEIGHT_WIDTH-1:0] tbl_im [NUM_CHANNELS][TABLE_DEPTH];
    logic                   in_packet, beat, boundary, go;
    logic                   last_dwell, last_entry, load, done_nxt;
    logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_nxt, dwell_eff;
    logic [ADDR_WIDTH:0]    num_eff;
    logic [ADDR_WIDTH-1:0]  idx_nxt;

    assign beat       = mon_tvalid & mon_tready;
    assign boundary   = beat & mon_tlast;
    assign busy       = state != IDLE;
    assign dwell_eff  = cfg_dwell == '0 ? DWELL_WIDTH'(1) : cfg_dwell;
    assign num_eff    = cfg_num_entries == '0 ? (ADDR_WIDTH+1)'(1) :
                        cfg_num_entries > DEPTH_N ? DEPTH_N : cfg_num_entries;
    // >= rather than == keeps the schedule moving if the live config shrinks mid-run
    assign last_dwell = dwell_cnt >= dwell_eff - 1'b1;
    assign last_entry = {1'b0, entry_idx} >= num_eff - 1'b1;
    assign go         = (state == IDLE && cfg_start && !cfg_stop && !in_packet) ||
                        (state == SYNC && boundary && !cfg_stop);

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_start && !cfg_stop) state_nxt = in_packet ? SYNC : RUN;
            SYNC:    if (cfg_stop) state_nxt = IDLE;
                     else if (boundary) state_nxt = RUN;
            RUN:     if (cfg_stop || (boundary && last_dwell && last_entry && !cfg_loop))
                         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        done_nxt  = 1'b0;
        idx_nxt   = entry_idx;
        dwell_nxt = dwell_cnt;
        if (go) begin
            load      = 1'b1;
            idx_nxt   = '0;
            dwell_nxt = '0;
        end else if (state == RUN && boundary && !cfg_stop) begin
            if (!last_dwell) dwell_nxt = dwell_cnt + 1'b1;
            else if (!last_entry || cfg_loop) begin
                load      = 1'b1;
                idx_nxt   = last_entry ? '0 : entry_idx + 1'b1;
                dwell_nxt = '0;
            end else done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn)
        if (!resetn)       in_packet <= 1'b0;
        else if (boundary) in_packet <= 1'b0;
        else if (beat)     in_packet <= 1'b1;

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            for (int c = 0; c < NUM_CHANNELS; c++)
                for (int i = 0; i < TABLE_DEPTH; i++) begin
                    tbl_re[c][i] <= '0;
                    tbl_im[c][i] <= '0;
                end
        end else if (cfg_wr_en) begin
            tbl_re[cfg_wr_ch][cfg_wr_idx] <= cfg_wr_real;
            tbl_im[cfg_wr_ch][cfg_wr_idx] <= cfg_wr_imag;
        end

    // Loads read the table before this edge's write lands
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            bWeight_real_bus <= '0;
            bWeight_imag_bus <= '0;
            weight_update    <= 1'b0;
            done             <= 1'b0;
            entry_idx        <= '0;
            dwell_cnt        <= '0;
        end else begin
            weight_update <= load;
            done          <= done_nxt;
            entry_idx     <= idx_nxt;
            dwell_cnt     <= dwell_nxt;
            if (load)
                for (int c = 0; c < NUM_CHANNELS; c++) begin
                    bWeight_real_bus[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= tbl_re[c][idx_nxt];
                    bWeight_imag_bus[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= tbl_im[c][idx_nxt];
                end
        end
endmodule

// File: tb/tb_bf_weight_sequencer.sv
// tb_bf_weight_sequencer: directed table-driven and hand-written sequence checks
// of weight scheduling, sync start, stall, stop, write/load collision and reset.
module tb_bf_weight_sequencer;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [1:0]  cfg_wr_ch = '0;
    logic [3:0]  cfg_wr_idx = '0;
    logic [7:0]  cfg_wr_real = '0, cfg_wr_imag = '0;
    logic [4:0]  cfg_num_entries = 5'd3;
    logic [15:0] cfg_dwell = 16'd1;
    logic        cfg_loop = 1'b0, cfg_start = 1'b0, cfg_stop = 1'b0;
    logic        mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
    logic [31:0] re_bus, im_bus;
    logic        weight_update, busy, done;
    logic [3:0]  entry_idx;
    int          n_cmp = 0, n_bad = 0;

    bf_weight_sequencer dut (
        .clock(clock), .resetn(resetn), .cfg_wr_en(cfg_wr_en), .cfg_wr_ch(cfg_wr_ch),
        .cfg_wr_idx(cfg_wr_idx), .cfg_wr_real(cfg_wr_real), .cfg_wr_imag(cfg_wr_imag),
        .cfg_num_entries(cfg_num_entries), .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop), .mon_tvalid(mon_tvalid),
        .mon_tready(mon_tready), .mon_tlast(mon_tlast), .bWeight_real_bus(re_bus),
        .bWeight_imag_bus(im_bus), .weight_update(weight_update), .entry_idx(entry_idx),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       v, l, s;
        logic [3:0] e;
        logic       b, d, u;
        logic [7:0] re, im;
    } vec_t;
    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic last);
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = last;
        step();
        mon_tvalid = 1'b0; mon_tlast = 1'b0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [3:0] idx, input logic [7:0] r, input logic [7:0] i);
        cfg_wr_en = 1'b1; cfg_wr_ch = ch; cfg_wr_idx = idx; cfg_wr_real = r; cfg_wr_imag = i;
        step();
        cfg_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_e [5];
        logic       exp_u [5];
        logic       stalled;
        // {valid, tlast, start, entry, busy, done, update, re0, im0}
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00};
        for (int i = 1; i < 4; i++)
            vecs[i] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 8'h20, 8'hF0};
        for (int i = 5; i < 8; i++)
            vecs[i] = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 8'h20, 8'hF0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 8'h7F, 8'h81};
        for (int i = 9; i < 12; i++)
            vecs[i] = '{1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 8'h7F, 8'h81};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 8'h7F, 8'h81};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 8'h7F, 8'h81};
        exp_e = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd0};
        exp_u = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (3) step();
        check("reset", {re_bus, im_bus[3:0], entry_idx, busy, done, weight_update},
              {32'h0, 4'h0, 4'h0, 3'b000});
        resetn = 1'b1;
        step();

        // three-entry one-shot schedule on channel 0
        wr(2'd0, 4'd0, 8'h10, 8'h00);
        wr(2'd0, 4'd1, 8'h20, 8'hF0);
        wr(2'd0, 4'd2, 8'h7F, 8'h81);
        for (int i = 0; i < 14; i++) begin
            mon_tvalid = vecs[i].v; mon_tready = vecs[i].v; mon_tlast = vecs[i].l;
            cfg_start = vecs[i].s;
            step();
            mon_tvalid = 1'b0; mon_tlast = 1'b0; cfg_start = 1'b0;
            check($sformatf("vec%0d", i),
                  {9'd0, entry_idx, busy, done, weight_update, re_bus[7:0], im_bus[7:0]},
                  {9'd0, vecs[i].e, vecs[i].b, vecs[i].d, vecs[i].u, vecs[i].re, vecs[i].im});
        end

        // start mid-packet waits in SYNC for the boundary
        beat(1'b0);
        beat(1'b0);
        pulse_start();
        check("sync_wait", {busy, weight_update, re_bus[7:0]}, {2'b10, 8'h7F});
        beat(1'b0);
        check("sync_hold", {busy, weight_update, re_bus[7:0]}, {2'b10, 8'h7F});
        beat(1'b1);
        check("sync_load", {entry_idx, busy, weight_update, re_bus[7:0]}, {4'd0, 2'b11, 8'h10});

        // back-pressured tlast must not advance until tready rises
        mon_tvalid = 1'b1; mon_tlast = 1'b1; mon_tready = 1'b0;
        stalled = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (entry_idx !== 4'd0 || weight_update !== 1'b0 || re_bus[7:0] !== 8'h10) stalled = 1'b0;
        end
        check("stall_hold", {31'd0, stalled}, 32'd1);
        mon_tready = 1'b1;
        step();
        mon_tvalid = 1'b0; mon_tlast = 1'b0;
        check("stall_release", {entry_idx, weight_update, re_bus[7:0]}, {4'd1, 1'b1, 8'h20});
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        check("stop_plain", {entry_idx, busy, done, weight_update, re_bus[7:0]}, {4'd1, 3'b000, 8'h20});

        // dwell 2, two entries, looping
        cfg_num_entries = 5'd2; cfg_dwell = 16'd2; cfg_loop = 1'b1;
        pulse_start();
        check("loop_start", {entry_idx, busy, weight_update, re_bus[7:0]}, {4'd0, 2'b11, 8'h10});
        for (int p = 0; p < 5; p++) begin
            check($sformatf("pkt%0d_entry", p + 1), {28'd0, entry_idx}, {28'd0, exp_e[p]});
            beat(1'b0);
            beat(1'b1);
            check($sformatf("pkt%0d_update", p + 1), {31'd0, weight_update}, {31'd0, exp_u[p]});
        end

        // stop beats a boundary that would otherwise load entry 1
        cfg_stop = 1'b1;
        beat(1'b1);
        cfg_stop = 1'b0;
        check("stop_boundary", {entry_idx, busy, done, weight_update, re_bus[7:0]}, {4'd0, 3'b000, 8'h10});
        step();
        check("stop_nodone", {entry_idx, busy, done, weight_update}, {4'd0, 3'b000});

        // write colliding with a wrap load: old value applies, new one on the next wrap
        wr(2'd1, 4'd0, 8'h11, 8'h01);
        wr(2'd1, 4'd1, 8'h22, 8'h02);
        cfg_dwell = 16'd1;
        pulse_start();
        check("ch1_e0", {re_bus[15:8], im_bus[15:8]}, {8'h11, 8'h01});
        beat(1'b1);
        check("ch1_e1", {re_bus[15:8], im_bus[15:8]}, {8'h22, 8'h02});
        cfg_wr_en = 1'b1; cfg_wr_ch = 2'd1; cfg_wr_idx = 4'd0; cfg_wr_real = 8'h33; cfg_wr_imag = 8'h44;
        beat(1'b1);
        cfg_wr_en = 1'b0;
        check("collide_old", {entry_idx, weight_update, re_bus[15:8], im_bus[15:8]}, {4'd0, 1'b1, 8'h11, 8'h01});
        beat(1'b1);
        beat(1'b1);
        check("collide_new", {entry_idx, re_bus[15:8], im_bus[15:8]}, {4'd0, 8'h33, 8'h44});

        // asynchronous reset in the middle of a packet
        beat(1'b0);
        #2 resetn = 1'b0;
        #1;
        check("async_reset", {re_bus[23:0], entry_idx, busy, done, weight_update},
              {24'd0, 4'd0, 3'b000});
        check("async_reset_hi", {re_bus[31:24], im_bus[31:8]}, 32'd0);
        step();
        resetn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
